// File: rtl/video_stream_deframer.sv
// Avalon-ST video deframer: classifies packets, forwards beats through one output
// register and tags video pixels with x/y. DEFRAMER_CTRL_PARSE_EN enables control-packet dimension parsing.
module video_stream_deframer #(
    parameter int IMAGE_W = 640,
    parameter int IMAGE_H = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_packet_video,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    input  logic        out_ready,
    output logic        frame_error
);
    typedef enum logic [1:0] {IDLE, VIDEO, CONTROL, SKIP} state_t;

    localparam logic [10:0] DEF_W = 11'(IMAGE_W);
    localparam logic [10:0] DEF_H = 11'(IMAGE_H);

    state_t      r_state;
    logic [10:0] r_width;
    logic [10:0] r_height;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_full;
    logic        r_excess;
    logic        r_out_valid;
    logic        r_out_sop;
    logic        r_out_eop;
    logic        r_out_video;
    logic        r_frame_error;
    logic [23:0] r_out_data;
    logic [10:0] r_out_x;
    logic [10:0] r_out_y;

    logic        w_xfer;
    logic [3:0]  w_type;
    logic        w_is_video_hdr;
    logic        w_is_ctrl_hdr;
    logic        w_last_col;
    logic        w_last_row;
    logic        w_frame_done;
    logic        w_vid_err;
    logic        w_hdr_err;

    assign in_ready       = out_ready || !r_out_valid;
    assign w_xfer         = in_valid && in_ready;
    assign w_type         = in_data[3:0];
    assign w_is_video_hdr = (w_type == 4'h0);
    assign w_is_ctrl_hdr  = (w_type == 4'hF);
    assign w_last_col     = (r_x == r_width - 11'd1);
    assign w_last_row     = (r_y == r_height - 11'd1);
    assign w_frame_done   = w_last_col && w_last_row;
    // First excess pixel, or eop arriving before the frame is complete.
    assign w_vid_err      = (r_full && !r_excess) || (in_eop && !r_full && !w_frame_done);

`ifdef DEFRAMER_CTRL_PARSE_EN
    logic [2:0]  r_ctrl_beats;
    logic [15:0] r_cw;
    logic [15:0] r_ch;
    logic [10:0] r_pend_w;
    logic [10:0] r_pend_h;
    logic        r_pend_valid;
    logic [15:0] w_cw_next;
    logic [15:0] w_ch_next;
    logic        w_ctrl_ok;

    always_comb begin
        w_cw_next = r_cw;
        w_ch_next = r_ch;
        case (r_ctrl_beats)
            3'd1: w_cw_next[15:4] = {in_data[3:0], in_data[11:8], in_data[19:16]};
            3'd2: begin
                w_cw_next[3:0]  = in_data[3:0];
                w_ch_next[15:8] = {in_data[11:8], in_data[19:16]};
            end
            3'd3: w_ch_next[7:0] = {in_data[3:0], in_data[11:8]};
            default: ;
        endcase
    end

    assign w_ctrl_ok = (r_ctrl_beats >= 3'd3) &&
                       (w_cw_next >= 16'd1) && (w_cw_next <= 16'd2047) &&
                       (w_ch_next >= 16'd1) && (w_ch_next <= 16'd2047);
    assign w_hdr_err = (r_state != IDLE) || (in_eop && (w_is_video_hdr || w_is_ctrl_hdr));
`else
    assign w_hdr_err = (r_state != IDLE) || (in_eop && w_is_video_hdr);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_width       <= DEF_W;
            r_height      <= DEF_H;
            r_x           <= 11'd0;
            r_y           <= 11'd0;
            r_full        <= 1'b0;
            r_excess      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_video   <= 1'b0;
            r_frame_error <= 1'b0;
            r_out_data    <= 24'd0;
            r_out_x       <= 11'd0;
            r_out_y       <= 11'd0;
`ifdef DEFRAMER_CTRL_PARSE_EN
            r_ctrl_beats  <= 3'd0;
            r_cw          <= 16'd0;
            r_ch          <= 16'd0;
            r_pend_w      <= 11'd0;
            r_pend_h      <= 11'd0;
            r_pend_valid  <= 1'b0;
`endif
        end else begin
            r_frame_error <= 1'b0;
            if (w_xfer) begin
                r_out_data <= in_data;
                if (in_sop) begin
                    r_out_valid   <= 1'b1;
                    r_out_sop     <= 1'b1;
                    r_out_eop     <= in_eop;
                    r_out_video   <= w_is_video_hdr;
                    r_out_x       <= 11'd0;
                    r_out_y       <= 11'd0;
                    r_frame_error <= w_hdr_err;
                    r_x           <= 11'd0;
                    r_y           <= 11'd0;
                    r_full        <= 1'b0;
                    r_excess      <= 1'b0;
                    if (in_eop)              r_state <= IDLE;
                    else if (w_is_video_hdr) r_state <= VIDEO;
                    else if (w_is_ctrl_hdr)  r_state <= CONTROL;
                    else                     r_state <= SKIP;
`ifdef DEFRAMER_CTRL_PARSE_EN
                    // Dimensions only change at a video header, never mid-frame.
                    if (w_is_video_hdr && r_pend_valid) begin
                        r_width      <= r_pend_w;
                        r_height     <= r_pend_h;
                        r_pend_valid <= 1'b0;
                    end
                    if (w_is_ctrl_hdr) begin
                        r_ctrl_beats <= 3'd1;
                        r_cw         <= 16'd0;
                        r_ch         <= 16'd0;
                        if (in_eop) r_pend_valid <= 1'b0;
                    end
`endif
                end else begin
                    case (r_state)
                        IDLE: r_out_valid <= 1'b0;
                        VIDEO: begin
                            r_out_valid   <= 1'b1;
                            r_out_sop     <= 1'b0;
                            r_out_eop     <= in_eop;
                            r_out_video   <= 1'b1;
                            r_out_x       <= r_x;
                            r_out_y       <= r_y;
                            r_frame_error <= w_vid_err;
                            r_excess      <= r_excess | r_full;
                            // Counters freeze at the last pixel so excess beats report (W-1, H-1).
                            if (!r_full) begin
                                if (w_frame_done) begin
                                    r_full <= 1'b1;
                                end else if (w_last_col) begin
                                    r_x <= 11'd0;
                                    r_y <= r_y + 11'd1;
                                end else begin
                                    r_x <= r_x + 11'd1;
                                end
                            end
                            if (in_eop) r_state <= IDLE;
                        end
                        default: begin
                            r_out_valid <= 1'b1;
                            r_out_sop   <= 1'b0;
                            r_out_eop   <= in_eop;
                            r_out_video <= 1'b0;
                            r_out_x     <= 11'd0;
                            r_out_y     <= 11'd0;
`ifdef DEFRAMER_CTRL_PARSE_EN
                            if (r_state == CONTROL) begin
                                r_cw <= w_cw_next;
                                r_ch <= w_ch_next;
                                if (r_ctrl_beats < 3'd4) r_ctrl_beats <= r_ctrl_beats + 3'd1;
                                if (in_eop) begin
                                    r_frame_error <= !w_ctrl_ok;
                                    r_pend_valid  <= w_ctrl_ok;
                                    r_pend_w      <= w_cw_next[10:0];
                                    r_pend_h      <= w_ch_next[10:0];
                                end
                            end
`endif
                            if (in_eop) r_state <= IDLE;
                        end
                    endcase
                end
            end else if (in_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_sop          = r_out_sop;
    assign out_eop          = r_out_eop;
    assign out_packet_video = r_out_video;
    assign out_x            = r_out_x;
    assign out_y            = r_out_y;
    assign out_red          = r_out_data[7:0];
    assign out_green        = r_out_data[15:8];
    assign out_blue         = r_out_data[23:16];
    assign frame_error      = r_frame_error;

endmodule

// File: tb/tb_video_stream_deframer.sv
// Directed table-driven bench for video_stream_deframer at IMAGE_W=4, IMAGE_H=2.
`timescale 1ns/1ps
module tb_video_stream_deframer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] in_data;
    logic        in_valid, in_sop, in_eop, in_ready;
    logic [7:0]  out_red, out_green, out_blue;
    logic        out_valid, out_sop, out_eop, out_packet_video;
    logic [10:0] out_x, out_y;
    logic        out_ready, frame_error;

    always #5 clk = ~clk;

    video_stream_deframer #(.IMAGE_W(4), .IMAGE_H(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_packet_video(out_packet_video), .out_x(out_x), .out_y(out_y),
        .out_ready(out_ready), .frame_error(frame_error)
    );

    typedef struct {
        logic        rst_n, vld, sop, eop;
        logic [23:0] dat;
        logic        ordy;
        logic        e_rdy, e_val, e_sop, e_eop, e_pv;
        logic [10:0] e_x, e_y;
        logic        e_err;
        logic [23:0] e_dat;
        logic        full;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

`ifdef DEFRAMER_CTRL_PARSE_EN
    localparam int EW = 3;
    localparam logic E_ERR = 1'b0;
`else
    localparam int EW = 4;
    localparam logic E_ERR = 1'b1;
`endif

    function automatic logic [23:0] pd(input int k);
        return 24'h112233 + 24'h010101 * 24'(k);
    endfunction

    task automatic row(input logic rst_n, vld, sop, eop, input logic [23:0] dat, input logic ordy,
                       input logic e_rdy, e_val, e_sop, e_eop, e_pv, input int e_x, e_y,
                       input logic e_err, input logic [23:0] e_dat, input logic full);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.sop = sop; v.eop = eop; v.dat = dat; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_sop = e_sop; v.e_eop = e_eop; v.e_pv = e_pv;
        v.e_x = 11'(e_x); v.e_y = 11'(e_y); v.e_err = e_err; v.e_dat = e_dat; v.full = full;
        tbl.push_back(v);
    endtask

    task automatic hdr(input logic [23:0] d, input logic eop, input logic err, input logic pv);
        row(1, 1, 1, eop, d, 1, 1, 1, 1, eop, pv, 0, 0, err, d, 0);
    endtask

    task automatic pix(input logic [23:0] d, input logic eop, input int x, input int y,
                       input logic err, input logic pv);
        row(1, 1, 0, eop, d, 1, 1, 1, 0, eop, pv, x, y, err, d, 0);
    endtask

    task automatic idle();
        row(1, 0, 0, 0, 24'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
    endtask

    task automatic drop(input logic [23:0] d);
        row(1, 1, 0, 0, d, 1, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 0);
    endtask

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("%s ok: %h", name, got);
        end
    endtask

    logic got_rdy;
    logic ok;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = 24'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_state",
            64'({in_ready, out_valid, out_sop, out_eop, out_packet_video, frame_error,
                 out_x, out_y, out_blue, out_green, out_red}),
            64'({1'b1, 5'b0, 11'd0, 11'd0, 24'h0}));

        // Nominal 4x2 frame
        hdr(24'h000000, 0, 0, 1);
        for (int p = 0; p < 8; p++) pix(pd(p), p == 7, p % 4, p / 4, 0, 1);
        idle();
        // Short frame: eop on 6th pixel, then a dropped stray beat
        hdr(24'h000000, 0, 0, 1);
        for (int p = 0; p < 6; p++) pix(pd(p + 8), p == 5, p % 4, p / 4, p == 5, 1);
        drop(pd(20));
        // Backpressure 1,0,0,1
        hdr(24'hABCD00, 0, 0, 1);
        pix(pd(30), 0, 0, 0, 0, 1);
        row(1, 1, 0, 0, pd(31), 0, 0, 1, 0, 0, 1, 0, 0, 0, pd(30), 0);
        row(1, 1, 0, 0, pd(31), 0, 0, 1, 0, 0, 1, 0, 0, 0, pd(30), 0);
        row(1, 1, 0, 0, pd(31), 1, 1, 1, 0, 0, 1, 1, 0, 0, pd(31), 0);
        for (int p = 2; p < 8; p++) pix(pd(30 + p), p == 7, p % 4, p / 4, 0, 1);
        idle();
        // Skip packets, sop mid-video, excess pixels, zero-pixel frame
        hdr(24'h000005, 0, 0, 0);
        pix(24'h123456, 0, 0, 0, 0, 0);
        pix(24'h654321, 1, 0, 0, 0, 0);
        hdr(24'h000005, 1, 0, 0);
        hdr(24'h000000, 0, 0, 1);
        pix(pd(40), 0, 0, 0, 0, 1);
        pix(pd(41), 0, 1, 0, 0, 1);
        hdr(24'h000010, 0, 1, 1);
        for (int p = 0; p < 8; p++) pix(pd(50 + p), 0, p % 4, p / 4, 0, 1);
        pix(pd(58), 0, 3, 1, 1, 1);
        pix(pd(59), 1, 3, 1, 0, 1);
        idle();
        hdr(24'h000000, 1, 1, 1);
        drop(pd(60));
        // Control packet W=3, H=2 followed by a 6-pixel frame
        hdr(24'h00000F, 0, 0, 0);
        pix(24'h000000, 0, 0, 0, 0, 0);
        pix(24'h000003, 0, 0, 0, 0, 0);
        pix(24'h000200, 1, 0, 0, 0, 0);
        hdr(24'h000000, 0, 0, 1);
        for (int p = 0; p < 6; p++) pix(pd(70 + p), p == 5, p % EW, p / EW, (p == 5) ? E_ERR : 1'b0, 1);
        idle();
        // Reset mid-frame after pixel 3
        hdr(24'h000000, 0, 0, 1);
        for (int p = 0; p < 3; p++) pix(pd(80 + p), 0, p, 0, 0, 1);
        row(0, 1, 0, 0, pd(83), 1, 1, 0, 0, 0, 0, 0, 0, 0, 24'h0, 1);
        drop(pd(84));
        drop(pd(85));
        hdr(24'h000000, 0, 0, 1);
        pix(pd(90), 0, 0, 0, 0, 1);
        pix(pd(91), 0, 1, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_n = tbl[i].rst_n; in_valid = tbl[i].vld; in_sop = tbl[i].sop;
            in_eop = tbl[i].eop; in_data = tbl[i].dat; out_ready = tbl[i].ordy;
            #1;
            got_rdy = in_ready;
            @(posedge clk);
            #1;
            ok = (got_rdy === tbl[i].e_rdy) && (out_valid === tbl[i].e_val) &&
                 (frame_error === tbl[i].e_err);
            if (tbl[i].e_val || tbl[i].full)
                ok = ok && (out_sop === tbl[i].e_sop) && (out_eop === tbl[i].e_eop) &&
                     (out_packet_video === tbl[i].e_pv) && (out_x === tbl[i].e_x) &&
                     (out_y === tbl[i].e_y) && ({out_blue, out_green, out_red} === tbl[i].e_dat);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy=%b val=%b sop=%b eop=%b vid=%b x=%0d y=%0d err=%b dat=%h; required rdy=%b val=%b sop=%b eop=%b vid=%b x=%0d y=%0d err=%b dat=%h",
                         i, got_rdy, out_valid, out_sop, out_eop, out_packet_video, out_x, out_y,
                         frame_error, {out_blue, out_green, out_red},
                         tbl[i].e_rdy, tbl[i].e_val, tbl[i].e_sop, tbl[i].e_eop, tbl[i].e_pv,
                         tbl[i].e_x, tbl[i].e_y, tbl[i].e_err, tbl[i].e_dat);
            end else begin
                $display("vec%0d ok: val=%b sop=%b eop=%b x=%0d y=%0d err=%b", i, out_valid,
                         out_sop, out_eop, out_x, out_y, frame_error);
            end
        end

        // Long stall: pixel 2 held off for three cycles, output must stay on pixel 1
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = pd(92); out_ready = 1'b0;
            #1;
            cmp("stall_in_ready", 64'(in_ready), 64'(1'b0));
            @(posedge clk);
            #1;
            cmp("stall_hold", 64'({out_valid, frame_error, out_x, out_y, out_blue, out_green, out_red}),
                64'({1'b1, 1'b0, 11'd1, 11'd0, pd(91)}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        cmp("release_in_ready", 64'(in_ready), 64'(1'b1));
        @(posedge clk);
        #1;
        cmp("release_pixel", 64'({out_valid, frame_error, out_x, out_y, out_blue, out_green, out_red}),
            64'({1'b1, 1'b0, 11'd2, 11'd0, pd(92)}));
        @(negedge clk);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/video_stream_deframer.md
VIDEO_STREAM_DEFRAMER -- requirements
Module: video_stream_deframer

Interface
REQ-001 Parameter IMAGE_W, default 640, active-line pixel count used until a valid control packet overrides it.
REQ-002 Parameter IMAGE_H, default 480, line count used until a valid control packet overrides it.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 in_data  in  24  Avalon-ST video beat {blue[23:16], green[15:8], red[7:0]}.
REQ-006 in_valid / in_sop / in_eop  in  1 each  beat qualifier, start of packet, end of packet.
REQ-007 in_ready  out  1  upstream backpressure.
REQ-008 out_red / out_green / out_blue  out  8 each  pixel components to the processing stage.
REQ-009 out_valid / out_sop / out_eop  out  1 each  registered beat qualifiers.
REQ-010 out_packet_video  out  1  high for every beat of a type-0 (video) packet.
REQ-011 out_x / out_y  out  11 each  column and row of the current pixel beat.
REQ-012 out_ready  in  1  downstream accept.
REQ-013 frame_error  out  1  one-cycle pulse on a framing violation.

Function
REQ-014 Transfer occurs when in_valid && in_ready; in_ready = out_ready || !out_valid (single output register, latency 1 cycle, no combinational valid-to-valid path).
REQ-015 Output register holds all out_* values stable while out_valid && !out_ready.
REQ-016 FSM states: IDLE, VIDEO, CONTROL, SKIP.
REQ-017 IDLE: non-sop beats are dropped (accepted, not forwarded); sop beat with in_data[3:0]=0 -> VIDEO, =0xF -> CONTROL, else -> SKIP.
REQ-018 Header (sop) beat is forwarded with out_sop=1, out_x=0, out_y=0, out_packet_video set per type.
REQ-019 VIDEO: each pixel beat is forwarded with current x,y; then x increments; at x = width-1, x wraps to 0 and y increments.
REQ-020 VIDEO eop after exactly width*height pixels -> IDLE, no error; any other count -> IDLE plus frame_error pulse.
REQ-021 Pixels beyond width*height are still forwarded with x,y held at (width-1, height-1); frame_error pulses once, on the first excess pixel.
REQ-022 CONTROL and SKIP beats are forwarded with out_packet_video=0 and x,y=0; eop returns to IDLE.
REQ-023 sop beat while not IDLE: frame_error pulses and the beat is treated as a new header per REQ-017.
REQ-024 sop and eop on the same beat: header forwarded, FSM stays/returns to IDLE; if type 0, frame_error pulses (zero-pixel frame).
REQ-025 Active width/height latch only on a VIDEO sop beat; dimensions never change mid-frame.

Reset
REQ-026 reset_n low at any clock edge: state IDLE, x=y=0, out_valid=out_sop=out_eop=out_packet_video=0, out_red/green/blue=0, frame_error=0, pending control dimensions discarded, active dimensions = IMAGE_W/IMAGE_H.
REQ-027 Reset mid-packet abandons the packet; subsequent non-sop beats are dropped per REQ-017.

Configuration
REQ-028 Macro DEFRAMER_CTRL_PARSE_EN defined: CONTROL decodes nibbles from data[3:0], [11:8], [19:16] of beats 1-3 (beat1: W[15:12],W[11:8],W[7:4]; beat2: W[3:0],H[15:12],H[11:8]; beat3: H[7:4],H[3:0],interlace) into pending dimensions.
REQ-029 With macro: pending dims adopted at next VIDEO sop only if control packet had >=4 beats and 1<=W<=2047, 1<=H<=2047; otherwise discarded and frame_error pulses at the control eop.
REQ-030 Without macro: control packet contents ignored, dimensions fixed at IMAGE_W/IMAGE_H, no control-related frame_error.

Verification
REQ-031 IMAGE_W=4, IMAGE_H=2, out_ready=1: header 0x000000 sop, 8 pixels, eop on 8th -> 9 outputs, last pixel x=3,y=1, out_eop=1, frame_error never asserted.
REQ-032 Same frame, eop on 6th pixel -> frame_error one-cycle pulse with eop output, FSM IDLE, next sop accepted.
REQ-033 out_ready toggling 1,0,0,1 during pixels -> in_ready low while stalled, out_* stable, no beat lost or duplicated, x/y sequence unchanged.
REQ-034 With DEFRAMER_CTRL_PARSE_EN: control packet W=3,H=2 then video frame of 6 pixels -> last pixel x=2,y=1, no error; without macro same stimulus -> frame_error (6 != 4*2 at IMAGE_W=4,IMAGE_H=2).
REQ-035 reset_n low for 1 cycle mid-frame after pixel 3 -> all outputs 0 next cycle, remaining pixels dropped, new sop frame counts from x=0,y=0.
REQ-036 sop type 0x5 packet of 3 beats -> forwarded with out_packet_video=0, x=y=0, no error; a sop mid-video -> frame_error pulse, new header forwarded.
